// File: rtl/conv_fprop_mul_arbiter.sv
// conv_fprop_mul_arbiter: round-robin share of one pipelined signed multiplier between NREQ requesters
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester operand handshake (req_ready at most one-hot)
//   req_din0/req_din1      packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready    one-hot product valid, per-requester accept
//   rsp_dout               product shared by all requesters
//   mul_ce/mul_din*/mul_dout  multiplier clock enable, operands and product
module conv_fprop_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 1,
   parameter int ID_W    = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DATA_W-1:0] req_din0,
   input  logic [NREQ*DATA_W-1:0] req_din1,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]      rsp_dout,
   output logic                   mul_ce,
   output logic [DATA_W-1:0]      mul_din0,
   output logic [DATA_W-1:0]      mul_din1,
   input  logic [DATA_W-1:0]      mul_dout
);
   logic [1:0]        sync_q;
   logic              run;
   logic              v_q  [MUL_LAT];
   logic [ID_W-1:0]   id_q [MUL_LAT];
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   gid;
   logic [ID_W:0]     sum;
   logic [2*NREQ-1:0] rot;
   logic              found;
   logic [NREQ-1:0]   gnt;

   // reset release is synchronised; grants stay off until it has propagated
   assign run       = sync_q[1];
   assign mul_ce    = !(v_q[MUL_LAT-1] && !rsp_ready[id_q[MUL_LAT-1]]);
   assign rsp_valid = v_q[MUL_LAT-1] ? NREQ'(1) << id_q[MUL_LAT-1] : '0;
   assign rsp_dout  = mul_dout;
   assign gnt       = (found && mul_ce && run) ? NREQ'(1) << gid : '0;
   assign req_ready = gnt;

   // rotate valids so bit k is requester ptr+k, pick the first set bit, map back
   always_comb begin
      rot   = {req_valid, req_valid} >> ptr;
      found = 1'b0;
      sum   = (ID_W+1)'(ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = (ID_W+1)'(ptr) + (ID_W+1)'(k);
         end
      end
      gid = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ)) : ID_W'(sum);
   end

   // with no grant gid equals ptr, so the multiplier sees ptr's operands
   always_comb begin
      mul_din0 = req_din0[DATA_W-1:0];
      mul_din1 = req_din1[DATA_W-1:0];
      for (int k = 0; k < NREQ; k++) begin
         if (gid == ID_W'(k)) begin
            mul_din0 = req_din0[k*DATA_W +: DATA_W];
            mul_din1 = req_din1[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         ptr    <= '0;
         for (int k = 0; k < MUL_LAT; k++) begin
            v_q[k]  <= 1'b0;
            id_q[k] <= '0;
         end
      end else begin
         sync_q <= {sync_q[0], 1'b1};
         if (mul_ce) begin
            v_q[0]  <= |gnt;
            id_q[0] <= gid;
            for (int k = 1; k < MUL_LAT; k++) begin
               v_q[k]  <= v_q[k-1];
               id_q[k] <= id_q[k-1];
            end
            if (|gnt) ptr <= (gid == ID_W'(NREQ-1)) ? '0 : gid + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_conv_fprop_mul_arbiter.sv
// tb_conv_fprop_mul_arbiter: bench for conv_fprop_mul_arbiter with a ce-qualified multiplier model
// Ports: none (top-level bench)
module tb_conv_fprop_mul_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int LAT  = 2;

   logic                 clk;
   logic                 reset_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*DW-1:0]   req_din0;
   logic [NREQ*DW-1:0]   req_din1;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [DW-1:0]        rsp_dout;
   logic                 mul_ce;
   logic [DW-1:0]        mul_din0;
   logic [DW-1:0]        mul_din1;
   logic [DW-1:0]        mul_dout;
   logic [DW-1:0]        a [NREQ];
   logic [DW-1:0]        b [NREQ];
   logic [DW-1:0]        p [LAT];
   int                   total;
   int                   bad;

   typedef struct {
      int          id;
      logic [31:0] prod;
      int          stage;
   } ent_t;
   ent_t q[$];
   int   mptr;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_p;
   } vec_t;
   vec_t vecs[6];

   conv_fprop_mul_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MUL_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_din0(req_din0), .req_din1(req_din1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout),
      .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout)
   );

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req_din0[g*DW +: DW] = a[g];
      assign req_din1[g*DW +: DW] = b[g];
   end

   function automatic logic [31:0] prod(input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] r;
      r = $signed(x) * $signed(y);
      return r[31:0];
   endfunction

   // multiplier model: LAT ce-qualified stages
   always_ff @(posedge clk) begin
      if (mul_ce) begin
         p[0] <= prod(mul_din0, mul_din1);
         for (int k = 1; k < LAT; k++) p[k] <= p[k-1];
      end
   end
   assign mul_dout = p[LAT-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp_v, $time);
      end
   endtask

   // scoreboard: entries age through the pipe on each enabled edge, tail is popped on delivery
   logic            m_tail;
   logic            m_ce;
   int              m_g;
   logic [NREQ-1:0] m_rv;
   logic [NREQ-1:0] m_rr;
   always @(negedge clk) begin
      #2;
      if (!reset_n) begin
         q.delete();
         mptr = 0;
      end else begin
         m_tail = q.size() > 0 && q[0].stage == LAT-1;
         m_rv   = m_tail ? NREQ'(1) << q[0].id : '0;
         chk("sb_rsp_valid", 64'(rsp_valid), 64'(m_rv));
         if (m_tail) chk("sb_rsp_dout", 64'(rsp_dout), 64'(q[0].prod));
         m_ce = !(m_tail && !rsp_ready[q[0].id]);
         chk("sb_mul_ce", 64'(mul_ce), 64'(m_ce));
         m_g = -1;
         if (m_ce)
            for (int k = 0; k < NREQ; k++)
               if (m_g < 0 && req_valid[(mptr + k) % NREQ]) m_g = (mptr + k) % NREQ;
         m_rr = (m_g >= 0) ? NREQ'(1) << m_g : '0;
         chk("sb_req_ready", 64'(req_ready), 64'(m_rr));
         if (m_ce) begin
            if (m_tail) void'(q.pop_front());
            foreach (q[i]) q[i].stage++;
            if (m_g >= 0) begin
               q.push_back('{m_g, prod(a[m_g], b[m_g]), 0});
               mptr = (m_g + 1) % NREQ;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         step();
         #3;
         n++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{0, 32'd3,         32'hFFFFFFFB, 32'hFFFFFFF1};
      vecs[1] = '{1, 32'h7FFFFFFF, 32'd2,         32'hFFFFFFFE};
      vecs[2] = '{2, 32'h80000000, 32'hFFFFFFFF,  32'h80000000};
      vecs[3] = '{3, 32'hFFFFFFF9, 32'hFFFFFFF7,  32'd63};
      vecs[4] = '{1, 32'h12345678, 32'd16,        32'h23456780};
      vecs[5] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF,  32'd1};
      for (int i = 0; i < NREQ; i++) begin
         a[i] = '0;
         b[i] = '0;
      end
      reset_n   = 1'b0;
      req_valid = '1;
      rsp_ready = '1;
      #12;
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_mul_ce", 64'(mul_ce), 64'd1);
      step();
      req_valid = '0;
      step();
      reset_n = 1'b1;
      repeat (4) step();

      // all requesters valid every cycle: strict 0,1,2,3 rotation
      for (int i = 0; i < NREQ; i++) begin
         a[i] = DW'(i);
         b[i] = 32'd7;
      end
      req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         #3;
         chk("rr_order", 64'(req_ready), 64'(NREQ'(1) << (c % NREQ)));
         step();
      end
      req_valid = '0;
      #3;
      drain();

      // sparse: ptr is 0 here, r3 alone granted, then r1 wins over r3
      step();
      req_valid = 4'b1000;
      #3;
      chk("sparse_r3", 64'(req_ready), 64'b1000);
      step();
      req_valid = 4'b1010;
      #3;
      chk("sparse_r1_first", 64'(req_ready), 64'b0010);
      step();
      #3;
      chk("sparse_r3_next", 64'(req_ready), 64'b1000);
      step();
      req_valid = '0;
      #3;
      drain();

      // single-request vectors: latency, one-hot owner and wrapped product
      foreach (vecs[v]) begin
         step();
         a[vecs[v].id] = vecs[v].a;
         b[vecs[v].id] = vecs[v].b;
         req_valid = NREQ'(1) << vecs[v].id;
         #3;
         chk("vec_ready", 64'(req_ready), 64'(req_valid));
         step();
         req_valid = '0;
         for (int k = 1; k < LAT; k++) begin
            #3;
            chk("vec_early", 64'(rsp_valid), 64'd0);
            step();
         end
         #3;
         chk("vec_valid", 64'(rsp_valid), 64'(NREQ'(1) << vecs[v].id));
         chk("vec_dout", 64'(rsp_dout), 64'(vecs[v].exp_p));
      end
      drain();

      // back-pressure on r2 at the tail
      for (int i = 0; i < NREQ; i++) begin
         a[i] = DW'(i);
         b[i] = 32'd7;
      end
      step();
      req_valid = 4'b0100;
      rsp_ready = 4'b1011;
      #3;
      chk("bp_issue_r2", 64'(req_ready), 64'b0100);
      step();
      req_valid = '1;
      step();
      for (int c = 0; c < 5; c++) begin
         #3;
         chk("bp_mul_ce", 64'(mul_ce), 64'd0);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_rsp_valid", 64'(rsp_valid), 64'b0100);
         chk("bp_rsp_dout", 64'(rsp_dout), 64'd14);
         step();
      end
      rsp_ready = '1;
      repeat (6) step();
      req_valid = '0;
      #3;
      drain();

      // reset with one product sitting at the tail
      step();
      a[1] = 32'd5;
      b[1] = 32'd6;
      req_valid = 4'b0010;
      #3;
      chk("rst_issue", 64'(req_ready), 64'b0010);
      step();
      req_valid = '0;
      rsp_ready = '0;
      step();
      #3;
      chk("rst_pre_valid", 64'(rsp_valid), 64'b0010);
      req_valid = '1;
      reset_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      step();
      step();
      req_valid = '0;
      rsp_ready = '1;
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #3;
         chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
         step();
      end
      req_valid = 4'b1100;
      #3;
      chk("rst_first_grant", 64'(req_ready), 64'b0100);
      step();
      req_valid = '0;
      #3;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
